// File: rtl/spi_tx_byte_queue.sv
// rtl/spi_tx_byte_queue.sv - byte FIFO with dispatch FSM feeding an SPI master start/data/done handshake
module spi_tx_byte_queue #(
    parameter int DEPTH      = 8,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output logic                       spi_start,
    output logic [DATA_W-1:0]          spi_data,
    input  logic                       spi_done,
    output logic                       busy,
    output logic [15:0]                bytes_sent
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_nxt;
    logic              push;
    logic              pop;

    state_t            state;
    state_t            state_nxt;
    logic              start_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic [GW-1:0]     gap_cnt;
    logic [GW-1:0]     gap_nxt;
    logic [15:0]       sent_nxt;

    // A push is refused whenever the registered full flag is set, even if a pop happens too
    assign push = wr_en & ~full;
    assign busy = (state != IDLE);

    // Storage array; no reset needed since occupancy tracking guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Next occupancy from the push/pop pair
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers and registered occupancy flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_FULL);
            empty <= (count_nxt == '0);
        end
    end

    // Sticky overflow; a rejected push beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Dispatch FSM register and its registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            spi_start  <= 1'b0;
            spi_data   <= '0;
            gap_cnt    <= '0;
            bytes_sent <= '0;
        end else begin
            state      <= state_nxt;
            spi_start  <= start_nxt;
            spi_data   <= data_nxt;
            gap_cnt    <= gap_nxt;
            bytes_sent <= sent_nxt;
        end
    end

    // Dispatch FSM next-state: pop head in IDLE, wait for done, then hold off for the gap
    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        data_nxt  = spi_data;
        gap_nxt   = gap_cnt;
        sent_nxt  = bytes_sent;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    data_nxt  = mem[rd_ptr];
                    pop       = 1'b1;
                    start_nxt = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (spi_done) begin
                    sent_nxt = bytes_sent + 16'd1;
                    if (GAP_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        gap_nxt   = GAP_LOAD;
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - GW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
